instruction_fetch: RTL and testbench

//  Fetch-stage initiator for the byte-addressed instruction memory. Owns the PC, drives it
//  to the memory and samples the combinational instruction word returned in the same cycle.

---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Bundle of fetch-stage signals: control in, instruction-memory port, IF/ID register out.
// Latency: none, wires only.
// Backpressure: stall is carried here and acted on by the fetch unit.
//  master (fetch unit): drives imem_pc, if_id_*, fetch_fault, fetch_count
//  slave  (environment): drives stall, flush, redirect_*, imem_instruction
interface instruction_fetch_if;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, imem_instruction,
        output imem_pc, if_id_pc, if_id_instruction, if_id_valid, fetch_fault, fetch_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, imem_instruction,
        input  imem_pc, if_id_pc, if_id_instruction, if_id_valid, fetch_fault, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory, fills IF/ID.
// Latency: an instruction presented at imem_pc appears in IF/ID one clock later.
// Backpressure: stall holds the PC and IF/ID; a redirect overrides stall and flush.
//  clk, reset (async, active-low), bus: instruction_fetch_if.master
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_fetch_if.master   bus
);
    // Highest word-aligned address that still lies inside the memory.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] if_id_pc, if_id_pc_nxt;
    logic [31:0] if_id_instr, if_id_instr_nxt;
    logic        if_id_valid, if_id_valid_nxt;
    logic        fault, fault_nxt;
    logic [31:0] count, count_nxt;
    logic        bad_pc;

    // The range check runs on the current PC, so 0x...FC + 4 can never wrap into a fetch.
    assign bad_pc = (pc[1:0] != 2'b00) || (pc > LAST_PC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fault       <= 1'b0;
            count       <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_id_pc    <= if_id_pc_nxt;
            if_id_instr <= if_id_instr_nxt;
            if_id_valid <= if_id_valid_nxt;
            fault       <= fault_nxt;
            count       <= count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        if_id_pc_nxt    = if_id_pc;
        if_id_instr_nxt = if_id_instr;
        if_id_valid_nxt = if_id_valid;
        fault_nxt       = fault;
        count_nxt       = count;

        unique case (state)
            BOOT: begin
                if_id_instr_nxt = NOP_INSTR;
                if_id_valid_nxt = 1'b0;
                state_nxt       = RUN;
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // A redirect wins over a bad PC, so a fault is never raised here.
                    pc_nxt          = bus.redirect_pc;
                    if_id_instr_nxt = NOP_INSTR;
                    if_id_valid_nxt = 1'b0;
                end else if (bus.stall) begin
                    if (bus.flush) begin
                        if_id_instr_nxt = NOP_INSTR;
                        if_id_valid_nxt = 1'b0;
                    end
                end else if (bad_pc) begin
                    if_id_instr_nxt = NOP_INSTR;
                    if_id_valid_nxt = 1'b0;
                    fault_nxt       = 1'b1;
                    state_nxt       = FAULT;
                end else if (bus.flush) begin
                    if_id_instr_nxt = NOP_INSTR;
                    if_id_valid_nxt = 1'b0;
                    pc_nxt          = pc + 32'd4;
                end else begin
                    if_id_pc_nxt    = pc;
                    if_id_instr_nxt = bus.imem_instruction;
                    if_id_valid_nxt = 1'b1;
                    pc_nxt          = pc + 32'd4;
                    count_nxt       = count + 32'd1;
                end
            end
            FAULT: begin
                // Frozen until software redirects; stall and flush have no effect.
                if_id_instr_nxt = NOP_INSTR;
                if_id_valid_nxt = 1'b0;
                if (bus.redirect_valid) begin
                    pc_nxt    = bus.redirect_pc;
                    fault_nxt = 1'b0;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign bus.imem_pc           = pc;
    assign bus.if_id_pc          = if_id_pc;
    assign bus.if_id_instruction = if_id_instr;
    assign bus.if_id_valid       = if_id_valid;
    assign bus.fetch_fault       = fault;
    assign bus.fetch_count       = count;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a scoreboard of expected IF/ID fetches.
// Latency: expected entries are pushed before the fetching edge and popped at the next negedge.
// Backpressure: edges taken with stall high deliver nothing new and pop nothing.
module tb_instruction_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    instruction_fetch_if ifc ();

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (256),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic        stall_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0062_9723;
        if (a == 32'h4)      return 32'h0073_02B3;
        if (a > 32'hFC)      return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign ifc.imem_instruction = mem_word(ifc.imem_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stall as seen by the DUT at the last edge; a stalled edge re-presents old IF/ID.
    always @(posedge clk) stall_seen = ifc.stall;

    always @(negedge clk) begin
        if (reset && ifc.if_id_valid && !stall_seen) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(ifc.if_id_valid), 32'h0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_pc", ifc.if_id_pc, e[63:32]);
                check("sb_instr", ifc.if_id_instruction, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur;
        logic [31:0] cnt;
        reset = 1'b0;
        ifc.stall = 1'b0;
        ifc.flush = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 32'h0;
        tick();
        tick();
        check("rst_pc", ifc.imem_pc, 32'h0);
        check("rst_valid", 32'(ifc.if_id_valid), 32'h0);
        check("rst_instr", ifc.if_id_instruction, NOP);
        check("rst_ifid_pc", ifc.if_id_pc, 32'h0);
        check("rst_fault", 32'(ifc.fetch_fault), 32'h0);
        check("rst_count", ifc.fetch_count, 32'h0);

        // Boot and first two fetches.
        reset = 1'b1;
        tick();
        check("boot_valid", 32'(ifc.if_id_valid), 32'h0);
        check("boot_pc", ifc.imem_pc, 32'h0);
        push_exp(32'h0);
        tick();
        check("f0_valid", 32'(ifc.if_id_valid), 32'h1);
        push_exp(32'h4);
        tick();
        check("f1_count", ifc.fetch_count, 32'd2);
        check("f1_pc", ifc.imem_pc, 32'h8);

        // Stall for three cycles at PC 8.
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", ifc.imem_pc, 32'h8);
            check("stall_ifid", ifc.if_id_pc, 32'h4);
            check("stall_count", ifc.fetch_count, 32'd2);
        end
        ifc.stall = 1'b0;
        push_exp(32'h8);
        tick();
        check("unstall_pc", ifc.imem_pc, 32'hC);
        check("unstall_count", ifc.fetch_count, 32'd3);

        // Redirect beats stall.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h40;
        ifc.stall = 1'b1;
        tick();
        check("redir_pc", ifc.imem_pc, 32'h40);
        check("redir_valid", 32'(ifc.if_id_valid), 32'h0);
        check("redir_instr", ifc.if_id_instruction, NOP);
        ifc.redirect_valid = 1'b0;
        ifc.stall = 1'b0;
        push_exp(32'h40);
        tick();
        check("redir_fetch", ifc.if_id_pc, 32'h40);

        // Misaligned redirect target faults one cycle later.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h42;
        tick();
        check("mis_nofault", 32'(ifc.fetch_fault), 32'h0);
        ifc.redirect_valid = 1'b0;
        tick();
        check("mis_fault", 32'(ifc.fetch_fault), 32'h1);
        check("mis_pc", ifc.imem_pc, 32'h42);
        ifc.stall = 1'b1;
        ifc.flush = 1'b1;
        tick();
        check("fault_frozen_pc", ifc.imem_pc, 32'h42);
        check("fault_frozen", 32'(ifc.fetch_fault), 32'h1);
        check("fault_valid", 32'(ifc.if_id_valid), 32'h0);
        ifc.stall = 1'b0;
        ifc.flush = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h10;
        tick();
        check("clr_fault", 32'(ifc.fetch_fault), 32'h0);
        check("clr_pc", ifc.imem_pc, 32'h10);
        ifc.redirect_valid = 1'b0;
        push_exp(32'h10);
        tick();
        check("clr_count", ifc.fetch_count, 32'd5);

        // Flush without stall advances PC but delivers a bubble.
        ifc.flush = 1'b1;
        tick();
        check("flush_valid", 32'(ifc.if_id_valid), 32'h0);
        check("flush_pc", ifc.imem_pc, 32'h18);
        ifc.flush = 1'b0;

        // Redirect in the same cycle as a bad PC: no fault.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h41;
        tick();
        ifc.redirect_pc = 32'h80;
        tick();
        check("redir_bad_fault", 32'(ifc.fetch_fault), 32'h0);
        check("redir_bad_pc", ifc.imem_pc, 32'h80);

        // Run off the end of memory.
        ifc.redirect_pc = 32'hF8;
        tick();
        ifc.redirect_valid = 1'b0;
        push_exp(32'hF8);
        tick();
        push_exp(32'hFC);
        tick();
        check("end_ifid", ifc.if_id_pc, 32'hFC);
        check("end_pc", ifc.imem_pc, 32'h100);
        tick();
        check("end_fault", 32'(ifc.fetch_fault), 32'h1);
        check("end_valid", 32'(ifc.if_id_valid), 32'h0);
        check("end_count", ifc.fetch_count, 32'd7);

        // Recover at 0x20, fetch once, then reset asynchronously mid-cycle.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h20;
        tick();
        ifc.redirect_valid = 1'b0;
        push_exp(32'h20);
        tick();
        check("pre_rst_count", ifc.fetch_count, 32'd8);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_pc", ifc.imem_pc, 32'h0);
        check("arst_valid", 32'(ifc.if_id_valid), 32'h0);
        check("arst_instr", ifc.if_id_instruction, NOP);
        check("arst_count", ifc.fetch_count, 32'h0);
        check("arst_fault", 32'(ifc.fetch_fault), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("reboot_valid", 32'(ifc.if_id_valid), 32'h0);
        push_exp(32'h0);
        tick();
        check("reboot_count", ifc.fetch_count, 32'd1);

        // Random stalls over a sequential stretch.
        cur = 32'h4;
        cnt = 32'd1;
        for (int i = 0; i < 12; i++) begin
            ifc.stall = 1'($urandom_range(0, 1));
            if (!ifc.stall) begin
                push_exp(cur);
                cur = cur + 32'd4;
                cnt = cnt + 32'd1;
            end
            tick();
            check("rnd_pc", ifc.imem_pc, cur);
        end
        ifc.stall = 1'b0;
        @(negedge clk);
        #1;
        check("rnd_count", ifc.fetch_count, cnt);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
